apb_dpmem_master: RTL and testbench

APB4 requester that sits directly upstream of the APB dual-port memory slave and drives its APB port. It converts a valid/ready command stream (read or write, address, data, byte strobes) into compliant SETUP/ACCESS transfers. It handles PREADY wait states, captures PRDATA/PSLVERR, and aborts stalled transfers with a wait-state timeout. Each completed transfer returns one response on a valid/ready response channel.

---
 rtl/apb_dpmem_master.sv | 181 ++++++++++++++++++
 tb/tb_apb_dpmem_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_dpmem_master.sv
// APB4 requester for the dual-port memory slave.
// Turns a valid/ready command stream into SETUP/ACCESS transfers.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_dpmem_pkg;
    localparam int APB_AW = `APB_ADDR_WIDTH;
    localparam int APB_DW = `APB_DATA_WIDTH;
    localparam int APB_SW = APB_DW / 8;
    typedef logic [APB_AW-1:0] addr_t;
    typedef logic [APB_DW-1:0] data_t;
    typedef logic [APB_SW-1:0] strb_t;
endpackage

module apb_dpmem_master
    import apb_dpmem_pkg::*;
#(
    parameter int          ADDR_WIDTH     = APB_AW,
    parameter int          DATA_WIDTH     = APB_DW,
    parameter int          STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TLIM =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   wait_q;
    logic            accept;
    logic            done;
    logic            abort;

    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  to_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // a late PREADY on the limit cycle still completes
                if (PREADY) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 &&
                             wait_q == TLIM[CW-1:0]) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q <= (state_d == ACCESS);
        end
    end

    // reads never carry write data or strobes onto the bus
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            pstrb_q  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else if (accept) begin
            wait_q <= '0;
        end else if (state_q == ACCESS && !PREADY && !abort) begin
            wait_q <= wait_q + CW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else if (done) begin
            rdata_q <= pwrite_q ? '0 : PRDATA;
            err_q   <= PSLVERR;
            to_q    <= 1'b0;
        end else if (abort) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_dpmem_master.sv
// Bench for apb_dpmem_master: directed cases plus random transfers
// against a transfer-level expectation model and a scripted APB slave.
module tb_apb_dpmem_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int errors = 0;
    int checks = 0;

    always #5 PCLK = ~PCLK;

    apb_dpmem_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STRB_WIDTH(SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PSTRB(PSTRB),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transfer. The slave raises PREADY on ACCESS cycle
    // waits+1; expectations come from the transfer-level rules only.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata,
                        input logic [SW-1:0] strb, input int waits,
                        input bit serr, input logic [DW-1:0] sdata,
                        input int hold);
        bit            to;
        int            k;
        logic [DW-1:0] erd;
        bit            eerr;
        int            c;
        int            pen;
        bit            seen;
        to   = (waits >= TO);
        k    = to ? TO : waits + 1;
        erd  = (wr || to) ? '0 : sdata;
        eerr = to || serr;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        chk("acc_rdy", cmd_ready, 1);
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_write = ~wr;
        c    = 1;
        pen  = 0;
        seen = 1'b0;
        while (c < 64 && !seen) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                chk("psel", PSEL, 1);
                chk("pwrite", PWRITE, wr);
                chk("paddr", PADDR, addr);
                chk("pwdata", PWDATA, wr ? wdata : '0);
                chk("pstrb", PSTRB, wr ? strb : '0);
                chk("crdy_busy", cmd_ready, 0);
                if (c == 1) chk("setup_pen", PENABLE, 0);
                if (PENABLE) begin
                    pen++;
                    PREADY  = (pen == waits + 1);
                    PSLVERR = serr && PREADY;
                    PRDATA  = PREADY ? sdata : DW'($urandom);
                end
                @(negedge PCLK);
                c++;
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk("rsp_seen", seen, 1);
        if (!seen) return;
        chk("latency", c, k + 2);
        chk("pen_cyc", pen, k);
        for (int h = 0; h <= hold; h++) begin
            chk("rv_hold", rsp_valid, 1);
            chk("rdata", rsp_rdata, erd);
            chk("rerr", rsp_err, eerr);
            chk("rto", rsp_timeout, to);
            chk("crdy_resp", cmd_ready, 0);
            chk("psel_idle", PSEL, 0);
            chk("pen_idle", PENABLE, 0);
            if (h < hold) @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("rv_clr", rsp_valid, 0);
        chk("crdy_back", cmd_ready, 1);
    endtask

    initial begin
        int r;
        int w;
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'h55AA55AA;
        cmd_strb  = 4'hF;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_crdy", cmd_ready, 1);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_pen", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_err", rsp_err, 0);
        PRESETn = 1'b1;
        #1;
        chk("post_crdy", cmd_ready, 1);
        chk("post_psel", PSEL, 0);
        @(negedge PCLK);
        chk("post_rv", rsp_valid, 0);
        chk("first_acc", PSEL, 1);
        repeat (2) @(negedge PCLK);
        PREADY = 1'b0;
        repeat (20) @(negedge PCLK);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("first_done", cmd_ready, 1);

        xfer(1, 32'h10, 32'hDEADBEEF, 4'b0101, 0, 0, 32'h0, 0);
        xfer(0, 32'h10, 32'h0, 4'hF, 3, 0, 32'h12345678, 0);
        xfer(0, 32'h14, 32'h0, 4'h0, 0, 1, 32'hCAFEF00D, 5);
        xfer(0, 32'h18, 32'h0, 4'h0, 40, 0, 32'h11111111, 1);
        xfer(0, 32'h18, 32'h0, 4'h0, 15, 0, 32'h22222222, 0);
        xfer(1, 32'h1C, 32'hA5A5A5A5, 4'b0000, 15, 1, 32'h0, 0);
        xfer(1, 32'h03, 32'h01020304, 4'hF, 16, 0, 32'h0, 2);

        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h77777777;
        cmd_strb  = 4'hF;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_pen", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        chk("mid_psel0", PSEL, 0);
        chk("mid_pen0", PENABLE, 0);
        chk("mid_rv0", rsp_valid, 0);
        chk("mid_crdy", cmd_ready, 1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("mid_rv1", rsp_valid, 0);
        chk("mid_psel1", PSEL, 0);
        xfer(1, 32'h24, 32'h89ABCDEF, 4'b1100, 1, 0, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 3);
            else if (r == 7) w = 15;
            else if (r == 8) w = 16;
            else             w = $urandom_range(0, 20);
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), w,
                 ($urandom_range(0, 3) == 0), $urandom,
                 $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
